// File: rtl/cr_huf_compPKG.sv
// Shared types for the Huffman compressor symbol scanner: frame-end marker,
// scan FSM states and the output beat. Feature macro: CR_HUF_COMP_SCAN_SKIP_ZERO_EN.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_compPKG;

  localparam int PKG_DAT_WIDTH      = 10;
  localparam int PKG_SYM_FREQ_WIDTH = 15;

  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    END       = 2'd1,
    PASS_THRU = 2'd2,
    MORE      = 2'd3
  } e_pipe_eob;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } e_scan_state;

  typedef struct packed {
    logic [PKG_DAT_WIDTH-1:0]      sym;
    logic [PKG_SYM_FREQ_WIDTH-1:0] freq;
    logic                          last;
    logic                          empty;
  } ob_beat_t;

endpackage

// File: rtl/cr_huf_comp_sym_scan_if.sv
// Beat channel between the scan FSM, the output register and the block boundary.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

interface cr_huf_comp_sym_scan_if;
  import cr_huf_compPKG::*;

  // A beat transfers on a clock edge where vld & rdy are both 1. Once vld is
  // raised the master holds vld and every payload field until that edge;
  // rdy may change freely and must not depend combinationally on vld.
  logic                   vld;
  logic                   rdy;
  ob_beat_t               beat;
  e_pipe_eob              eob;
  logic [PKG_DAT_WIDTH:0] num_sym;

  modport master (output vld, output beat, output eob, output num_sym, input rdy);
  modport slave  (input vld, input beat, input eob, input num_sym, output rdy);

endinterface

// File: rtl/cr_huf_comp_sym_scan_ob.sv
// Single-entry output register: accepts a new beat whenever it is empty or its
// current beat is being taken downstream in the same cycle.
module cr_huf_comp_sym_scan_ob
  import cr_huf_compPKG::*;
(
  input  logic                  clk_gated,
  input  logic                  rst_n,
  cr_huf_comp_sym_scan_if.slave  ld,
  cr_huf_comp_sym_scan_if.master out
);

  logic                   vld_q;
  ob_beat_t               beat_q;
  e_pipe_eob              eob_q;
  logic [PKG_DAT_WIDTH:0] num_q;

  assign ld.rdy = !vld_q || out.rdy;

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      beat_q <= '0;
      eob_q  <= MIDDLE;
      num_q  <= '0;
    end else if (ld.vld && ld.rdy) begin
      vld_q  <= 1'b1;
      beat_q <= ld.beat;
      eob_q  <= ld.eob;
      num_q  <= ld.num_sym;
    end else if (out.rdy) begin
      vld_q  <= 1'b0;
    end
  end

  assign out.vld     = vld_q;
  assign out.beat    = beat_q;
  assign out.eob     = eob_q;
  assign out.num_sym = num_q;

endmodule

// File: rtl/cr_huf_comp_sym_scan.sv
// Symbol scanner: snapshots a histogram at frame end and streams one
// (symbol, frequency) beat per index. Feature macro: CR_HUF_COMP_SCAN_SKIP_ZERO_EN.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module cr_huf_comp_sym_scan
  import cr_huf_compPKG::*;
#(
  parameter int DAT_WIDTH        = PKG_DAT_WIDTH,
  parameter int SYM_FREQ_WIDTH   = PKG_SYM_FREQ_WIDTH,
  parameter int CNTRL_WIDTH      = 1,
  parameter int MAX_NUM_SYM_USED = 576
) (
  input  logic                                            clk_gated,
  input  logic                                            rst_n,
  input  logic [MAX_NUM_SYM_USED-1:0][SYM_FREQ_WIDTH-1:0] new_freq,
  input  e_pipe_eob                                       eob,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0]               seq_id,
  input  logic [CNTRL_WIDTH-1:0]                          meta,
  input  logic [DAT_WIDTH-1:0]                            sym_lo,
  input  logic [DAT_WIDTH-1:0]                            sym_hi,
  output logic                                            not_ready,
  output logic                                            ss_vld,
  input  logic                                            ss_rdy,
  output logic [DAT_WIDTH-1:0]                            ss_sym,
  output logic [SYM_FREQ_WIDTH-1:0]                       ss_freq,
  output logic                                            ss_last,
  output logic                                            ss_empty,
  output e_pipe_eob                                       ss_eob,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0]               ss_seq_id,
  output logic [CNTRL_WIDTH-1:0]                          ss_meta,
  output logic [DAT_WIDTH:0]                              ss_num_sym
);

  localparam logic [DAT_WIDTH:0] MAX_SYM = (DAT_WIDTH+1)'(MAX_NUM_SYM_USED);

  e_scan_state                             state_q, state_d;
  logic [DAT_WIDTH-1:0]                    idx_q, idx_d;
  logic [DAT_WIDTH:0]                      cnt_q, cnt_d;
  logic                                    not_ready_q;
  logic [MAX_NUM_SYM_USED-1:0][SYM_FREQ_WIDTH-1:0] freq_q;
  logic [DAT_WIDTH-1:0]                    lo_q, hi_q;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0]       seq_q;
  logic [CNTRL_WIDTH-1:0]                  meta_q;
  e_pipe_eob                               eob_q;
  logic                                    empty_q;

  logic                      capture, frame_empty, is_last, emit;
  logic [SYM_FREQ_WIDTH-1:0] cur_freq;

  cr_huf_comp_sym_scan_if ld_if ();
  cr_huf_comp_sym_scan_if out_if ();

  assign capture  = (state_q == IDLE) && (eob != MIDDLE);
  assign cur_freq = freq_q[idx_q];
  assign is_last  = (idx_q == hi_q);

  // Out-of-range or inverted bounds collapse to the same single empty beat as
  // a zero count at sym_lo, so downstream never sees a half-formed frame.
  always_comb begin
    frame_empty = 1'b1;
    if (({1'b0, sym_lo} < MAX_SYM) && ({1'b0, sym_hi} < MAX_SYM) && (sym_lo <= sym_hi))
      frame_empty = (new_freq[sym_lo] == '0);
  end

  // The sym_hi beat is always emitted so every frame carries a last beat.
`ifdef CR_HUF_COMP_SCAN_SKIP_ZERO_EN
  assign emit = is_last || (cur_freq != '0);
`else
  assign emit = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    ld_if.vld      = 1'b0;
    ld_if.beat     = '{sym: idx_q, freq: cur_freq, last: is_last, empty: 1'b0};
    ld_if.eob      = is_last ? eob_q : MIDDLE;
    ld_if.num_sym  = cnt_q + (DAT_WIDTH+1)'(1);
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SCAN;
          idx_d   = sym_lo;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (empty_q) begin
          ld_if.vld     = 1'b1;
          ld_if.beat    = '{sym: lo_q, freq: '0, last: 1'b1, empty: 1'b1};
          ld_if.eob     = eob_q;
          ld_if.num_sym = '0;
          if (ld_if.rdy) state_d = DRAIN;
        end else if (emit) begin
          ld_if.vld = 1'b1;
          if (ld_if.rdy) begin
            cnt_d = cnt_q + (DAT_WIDTH+1)'(1);
            if (is_last) state_d = DRAIN;
            else         idx_d   = idx_q + DAT_WIDTH'(1);
          end
        end else begin
          idx_d = idx_q + DAT_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (out_if.vld && out_if.rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      not_ready_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      seq_q       <= '0;
      meta_q      <= '0;
      eob_q       <= MIDDLE;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      not_ready_q <= (state_d != IDLE);
      if (capture) begin
        lo_q    <= sym_lo;
        hi_q    <= sym_hi;
        seq_q   <= seq_id;
        meta_q  <= meta;
        eob_q   <= eob;
        empty_q <= frame_empty;
      end
    end
  end

  // The histogram snapshot is only meaningful after a capture, so it has no reset.
  always_ff @(posedge clk_gated) begin
    if (capture) freq_q <= new_freq;
  end

  cr_huf_comp_sym_scan_ob u_ob (
    .clk_gated (clk_gated),
    .rst_n     (rst_n),
    .ld        (ld_if),
    .out       (out_if)
  );

  assign out_if.rdy = ss_rdy;
  assign not_ready  = not_ready_q;
  assign ss_vld     = out_if.vld;
  assign ss_sym     = out_if.beat.sym;
  assign ss_freq    = out_if.beat.freq;
  assign ss_last    = out_if.beat.last;
  assign ss_empty   = out_if.beat.empty;
  assign ss_eob     = out_if.eob;
  assign ss_num_sym = out_if.num_sym;
  assign ss_seq_id  = seq_q;
  assign ss_meta    = meta_q;

endmodule

// File: tb/tb_cr_huf_comp_sym_scan.sv
// Bench for cr_huf_comp_sym_scan: directed frames plus randomized histograms
// checked against a list-of-beats model of the frame rules.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module tb_cr_huf_comp_sym_scan;
  import cr_huf_compPKG::*;

  localparam int SQW = `CREOLE_HC_SEQID_WIDTH;
  localparam int W   = SQW + 41;

  logic                   clk_gated = 1'b0;
  logic                   rst_n;
  logic [575:0][14:0]     new_freq;
  e_pipe_eob              eob;
  logic [SQW-1:0]         seq_id;
  logic [0:0]             meta;
  logic [9:0]             sym_lo, sym_hi;
  logic                   not_ready, ss_vld, ss_rdy, ss_last, ss_empty;
  logic [9:0]             ss_sym;
  logic [14:0]            ss_freq;
  e_pipe_eob              ss_eob;
  logic [SQW-1:0]         ss_seq_id;
  logic [0:0]             ss_meta;
  logic [10:0]            ss_num_sym;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int stab_err = 0;

  always #5 clk_gated = ~clk_gated;

  cr_huf_comp_sym_scan dut (
    .clk_gated (clk_gated), .rst_n (rst_n), .new_freq (new_freq), .eob (eob),
    .seq_id (seq_id), .meta (meta), .sym_lo (sym_lo), .sym_hi (sym_hi),
    .not_ready (not_ready), .ss_vld (ss_vld), .ss_rdy (ss_rdy), .ss_sym (ss_sym),
    .ss_freq (ss_freq), .ss_last (ss_last), .ss_empty (ss_empty), .ss_eob (ss_eob),
    .ss_seq_id (ss_seq_id), .ss_meta (ss_meta), .ss_num_sym (ss_num_sym)
  );

  cr_huf_comp_sym_scan_if mon_if ();
  assign mon_if.vld     = ss_vld;
  assign mon_if.rdy     = ss_rdy;
  assign mon_if.beat    = '{sym: ss_sym, freq: ss_freq, last: ss_last, empty: ss_empty};
  assign mon_if.eob     = ss_eob;
  assign mon_if.num_sym = ss_num_sym;

  function automatic logic [W-1:0] pk(input logic [9:0] s, input logic [14:0] f, input logic l,
                                      input logic e, input e_pipe_eob eb, input logic [10:0] n,
                                      input logic [SQW-1:0] sq, input logic m);
    return {s, f, l, e, eb, n, sq, m};
  endfunction

  function automatic logic [W-1:0] pack_obs();
    return pk(mon_if.beat.sym, mon_if.beat.freq, mon_if.beat.last, mon_if.beat.empty,
              mon_if.eob, mon_if.num_sym, ss_seq_id, ss_meta[0]);
  endfunction

  // Reference model: the frame as a list of beats derived from the histogram.
  task automatic build_exp(input int lo, input int hi, input logic [SQW-1:0] sq,
                           input logic m, input e_pipe_eob eb);
    int k;
    exp_q.delete();
    if (lo >= 576 || hi >= 576 || lo > hi || new_freq[lo] == 15'd0) begin
      exp_q.push_back(pk(10'(lo), 15'd0, 1'b1, 1'b1, eb, 11'd0, sq, m));
    end else begin
      k = 0;
      for (int i = lo; i <= hi; i++) begin
`ifdef CR_HUF_COMP_SCAN_SKIP_ZERO_EN
        if (new_freq[i] == 15'd0 && i != hi) continue;
`endif
        k++;
        exp_q.push_back(pk(10'(i), new_freq[i], i == hi, 1'b0, (i == hi) ? eb : MIDDLE,
                           11'(k), sq, m));
      end
    end
  endtask

  task automatic fill_hist(input int pct);
    for (int i = 0; i < 576; i++)
      new_freq[i] = ($urandom_range(99) < pct) ? 15'($urandom_range(32767, 1)) : 15'd0;
  endtask

  // Called at posedge+1 while IDLE; returns at posedge+1 of the first SCAN cycle.
  task automatic start_frame(input int lo, input int hi, input logic [SQW-1:0] sq,
                             input logic m, input e_pipe_eob eb);
    sym_lo = 10'(lo); sym_hi = 10'(hi); seq_id = sq; meta = m; eob = eb;
    @(posedge clk_gated); #1;
    eob = MIDDLE;
  endtask

  task automatic collect(input int rdy_pct, input int budget, output bit done, output int first_vld);
    logic [W-1:0] cur, prev;
    bit have_prev;
    done = 0; first_vld = -1; have_prev = 0; prev = '0;
    obs_q.delete();
    for (int c = 0; c < budget && !done; c++) begin
      ss_rdy = ($urandom_range(99) < rdy_pct);
      @(negedge clk_gated);
      cur = pack_obs();
      if (have_prev && (cur !== prev || mon_if.vld !== 1'b1)) stab_err++;
      have_prev = mon_if.vld && !mon_if.rdy;
      prev = cur;
      if (mon_if.vld === 1'b1 && first_vld < 0) first_vld = c;
      if (mon_if.vld && mon_if.rdy) begin
        obs_q.push_back(cur);
        if (mon_if.beat.last) done = 1;
      end
      @(posedge clk_gated); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss_rdy = 1'b0; eob = MIDDLE; new_freq = '0;
    seq_id = '0; meta = '0; sym_lo = '0; sym_hi = '0;
    #12;
    n_checks++;
    if (ss_vld !== 1'b0 || pack_obs() !== pk(10'd0, 15'd0, 1'b0, 1'b0, MIDDLE, 11'd0, '0, 1'b0))
      $display("FAIL reset_outputs got vld=%b beat=%h req vld=0 beat=0", ss_vld, pack_obs());
    else n_pass++;
    n_checks++;
    if (not_ready !== 1'b0) $display("FAIL reset_not_ready got %b req 0", not_ready);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL reset_state got %0d req IDLE", dut.state_q);
    else n_pass++;
    @(posedge clk_gated); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_gated);
    #1;
  endtask

  task automatic test_basic();
    bit done; int fv;
    new_freq = '0; new_freq[3] = 15'd5; new_freq[7] = 15'd2;
    build_exp(3, 7, 8'h11, 1'b1, END);
    ss_rdy = 1'b1;
    start_frame(3, 7, 8'h11, 1'b1, END);
    n_checks++;
    if (not_ready !== 1'b1 || ss_vld !== 1'b0)
      $display("FAIL basic_scan_entry got nr=%b vld=%b req nr=1 vld=0", not_ready, ss_vld);
    else n_pass++;
    collect(100, 200, done, fv);
    n_checks++;
    if (fv != 1) $display("FAIL basic_latency got %0d req 1", fv); else n_pass++;
    n_checks++;
    if (!done || obs_q.size() != exp_q.size())
      $display("FAIL basic_beats got %0d (done=%0b) req %0d", obs_q.size(), done, exp_q.size());
    else begin
      n_pass++;
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL basic_beat%0d got %h req %h", i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (not_ready !== 1'b0 || ss_vld !== 1'b0)
      $display("FAIL basic_idle_after got nr=%b vld=%b req nr=0 vld=0", not_ready, ss_vld);
    else n_pass++;
  endtask

  task automatic test_empty();
    int lo_t[4] = '{5, 30, 100, 700};
    int hi_t[4] = '{20, 10, 600, 800};
    bit done; int fv;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) new_freq = '0; else fill_hist(100);
      build_exp(lo_t[t], hi_t[t], 8'(t + 32), 1'b0, PASS_THRU);
      ss_rdy = 1'b1;
      start_frame(lo_t[t], hi_t[t], 8'(t + 32), 1'b0, PASS_THRU);
      collect(70, 100, done, fv);
      n_checks++;
      if (!done || obs_q.size() != 1 || obs_q[0] !== exp_q[0])
        $display("FAIL empty_case%0d got %0d beats first %h req 1 beat %h", t, obs_q.size(),
                 (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    bit done; int fv, err;
    logic [W-1:0] first;
    fill_hist(40); new_freq[20] = 15'd1234;
    build_exp(20, 30, 8'h5a, 1'b1, MORE);
    ss_rdy = 1'b0;
    start_frame(20, 30, 8'h5a, 1'b1, MORE);
    @(posedge clk_gated); #1;
    first = pack_obs(); err = 0;
    repeat (10) begin
      @(posedge clk_gated); #1;
      if (ss_vld !== 1'b1 || pack_obs() !== first || not_ready !== 1'b1) err++;
    end
    n_checks++;
    if (err != 0) $display("FAIL stall_hold got %0d unstable cycles req 0", err); else n_pass++;
    n_checks++;
    if (first !== exp_q[0]) $display("FAIL stall_first got %h req %h", first, exp_q[0]); else n_pass++;
    collect(100, 100, done, fv);
    n_checks++;
    if (!done || obs_q.size() != exp_q.size())
      $display("FAIL stall_beats got %0d (done=%0b) req %0d", obs_q.size(), done, exp_q.size());
    else begin
      n_pass++;
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL stall_beat%0d got %h req %h", i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_second_eob();
    bit done; int fv;
    fill_hist(50); new_freq[10] = 15'd100;
    build_exp(10, 40, 8'h21, 1'b0, PASS_THRU);
    ss_rdy = 1'b1;
    start_frame(10, 40, 8'h21, 1'b0, PASS_THRU);
    eob = END; seq_id = 8'h99; meta = 1'b1; sym_lo = 10'd0; sym_hi = 10'd5;
    fill_hist(80);
    @(posedge clk_gated); #1;
    eob = MIDDLE;
    collect(60, 400, done, fv);
    n_checks++;
    if (!done || obs_q.size() != exp_q.size())
      $display("FAIL second_eob_beats got %0d (done=%0b) req %0d", obs_q.size(), done, exp_q.size());
    else begin
      n_pass++;
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL second_eob_beat%0d got %h req %h", i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit done; int fv, err;
    int lo;
    fill_hist(50); new_freq[0] = 15'd1;
    ss_rdy = 1'b1;
    start_frame(0, 200, 8'h33, 1'b1, END);
    repeat (5) @(posedge clk_gated);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ss_vld !== 1'b0 || not_ready !== 1'b0)
      $display("FAIL reset_mid_now got vld=%b nr=%b req vld=0 nr=0", ss_vld, not_ready);
    else n_pass++;
    @(posedge clk_gated); #1;
    rst_n = 1'b1;
    err = 0;
    repeat (4) begin
      @(posedge clk_gated); #1;
      if (ss_vld !== 1'b0 || not_ready !== 1'b0) err++;
    end
    n_checks++;
    if (err != 0) $display("FAIL reset_mid_quiet got %0d active cycles req 0", err); else n_pass++;
    fill_hist(40);
    lo = $urandom_range(500, 0);
    new_freq[lo] = 15'd77;
    build_exp(lo, lo + 20, 8'h44, 1'b0, END);
    start_frame(lo, lo + 20, 8'h44, 1'b0, END);
    collect(80, 300, done, fv);
    n_checks++;
    if (!done || obs_q.size() != exp_q.size())
      $display("FAIL reset_mid_next got %0d (done=%0b) req %0d", obs_q.size(), done, exp_q.size());
    else begin
      n_pass++;
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL reset_mid_beat%0d got %h req %h", i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_max_sym();
    bit done; int fv;
    fill_hist(20); new_freq[575] = 15'd32767;
    ss_rdy = 1'b1;
    start_frame(575, 575, 8'hfe, 1'b1, END);
    n_checks++;
    if (not_ready !== 1'b1) $display("FAIL max_not_ready got %b req 1", not_ready); else n_pass++;
    collect(100, 20, done, fv);
    n_checks++;
    if (!done || fv != 1 || obs_q.size() != 1 ||
        obs_q[0] !== pk(10'd575, 15'd32767, 1'b1, 1'b0, END, 11'd1, 8'hfe, 1'b1))
      $display("FAIL max_beat got %0d beats lat=%0d first %h req 1 beat lat=1", obs_q.size(), fv,
               (obs_q.size() > 0) ? obs_q[0] : '0);
    else n_pass++;
    n_checks++;
    if (not_ready !== 1'b0) $display("FAIL max_not_ready_drop got %b req 0", not_ready); else n_pass++;
  endtask

  task automatic test_random();
    bit done; int fv, lo, hi, bad, sel;
    logic [SQW-1:0] sq;
    e_pipe_eob eb;
    bad = 0; stab_err = 0;
    for (int f = 0; f < 30; f++) begin
      fill_hist($urandom_range(90, 10));
      lo = $urandom_range(575, 0);
      hi = lo + $urandom_range(60, 0);
      if (hi > 575) hi = 575;
      sel = $urandom_range(9, 0);
      if (sel == 0) begin lo = 300; hi = 299; end
      else if (sel == 1) hi = $urandom_range(1023, 576);
      else if (sel == 2) lo = $urandom_range(1023, 576);
      sq = SQW'($urandom);
      eb = e_pipe_eob'($urandom_range(3, 1));
      build_exp(lo, hi, sq, sq[0], eb);
      start_frame(lo, hi, sq, sq[0], eb);
      collect($urandom_range(100, 30), 1000, done, fv);
      if (!done || obs_q.size() != exp_q.size()) bad++;
      else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL random_frames got %0d bad beats/frames req 0", bad); else n_pass++;
    n_checks++;
    if (stab_err != 0) $display("FAIL random_stability got %0d changes under stall req 0", stab_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_second_eob();
    test_reset_mid();
    test_max_sym();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
